// File: rtl/readout_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// readout_sequencer : streams a captured multi-channel waveform as framed bytes
// Rev 1.0
// ---------------------------------------------------------------------------
module readout_sequencer #(
  parameter int RAM_WIDTH  = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 readout_req,
  input  logic                 data_ready,
  input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
  input  logic [RAM_WIDTH-1:0] triggerpoint,
  input  logic [RAM_WIDTH-1:0] nsmp,
  input  logic [3:0]           chanmask,
  input  logic                 rearm,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddress,
  output logic [1:0]           chansel,
  input  logic [7:0]           ram_q,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 startTrigger
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NAK  = 3'd1,
    S_HDR0 = 3'd2,
    S_HDR1 = 3'd3,
    S_RD   = 3'd4,
    S_WAIT = 3'd5,
    S_SEND = 3'd6,
    S_FIN  = 3'd7
  } state_t;

  localparam logic [1:0] c_LAT_LAST = 2'(RD_LATENCY - 1);

  state_t               state_q;
  logic [RAM_WIDTH-1:0] base_q;
  logic [RAM_WIDTH-1:0] nsmp_q;
  logic [3:0]           mask_q;
  logic                 rearm_q;
  logic [RAM_WIDTH-1:0] idx_q;
  logic [1:0]           lat_q;

  logic [1:0]           first_ch_d;
  logic [1:0]           next_ch_d;
  logic                 next_found_d;
  logic [RAM_WIDTH-1:0] idx_inc_d;

  // Descending scans leave the lowest qualifying channel in the result.
  always_comb begin
    first_ch_d   = 2'd0;
    next_ch_d    = chansel;
    next_found_d = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_ch_d = i[1:0];
      end
      if (mask_q[i] && (i > int'(chansel))) begin
        next_found_d = 1'b1;
        next_ch_d    = i[1:0];
      end
    end
    idx_inc_d = idx_q + RAM_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      nsmp_q       <= '0;
      mask_q       <= '0;
      rearm_q      <= 1'b0;
      idx_q        <= '0;
      lat_q        <= '0;
      rden         <= 1'b0;
      rdaddress    <= '0;
      chansel      <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      startTrigger <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (readout_req) begin
            base_q   <= wraddress_triggerpoint - triggerpoint;
            nsmp_q   <= nsmp;
            mask_q   <= chanmask;
            rearm_q  <= rearm;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            if (data_ready) begin
              tx_data <= 8'hA5;
              state_q <= S_HDR0;
            end else begin
              tx_data <= 8'hEE;
              state_q <= S_NAK;
            end
          end
        end
        S_NAK: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state_q  <= S_FIN;
          end
        end
        S_HDR0: begin
          if (tx_ready) begin
            tx_data <= {4'h0, mask_q};
            state_q <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if ((mask_q == 4'h0) || (nsmp_q == '0)) begin
              startTrigger <= rearm_q;
              state_q      <= S_FIN;
            end else begin
              chansel   <= first_ch_d;
              idx_q     <= '0;
              rden      <= 1'b1;
              rdaddress <= base_q;
              state_q   <= S_RD;
            end
          end
        end
        S_RD: begin
          rden    <= 1'b0;
          lat_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == c_LAT_LAST) begin
            tx_data  <= ram_q;
            tx_valid <= 1'b1;
            state_q  <= S_SEND;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (idx_inc_d < nsmp_q) begin
              idx_q     <= idx_inc_d;
              rden      <= 1'b1;
              rdaddress <= base_q + idx_inc_d;
              state_q   <= S_RD;
            end else if (next_found_d) begin
              chansel   <= next_ch_d;
              idx_q     <= '0;
              rden      <= 1'b1;
              rdaddress <= base_q;
              state_q   <= S_RD;
            end else begin
              startTrigger <= rearm_q;
              state_q      <= S_FIN;
            end
          end
        end
        S_FIN: begin
          startTrigger <= 1'b0;
          busy         <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_readout_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_readout_sequencer : scoreboard bench for readout_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_readout_sequencer;
  localparam int RW  = 10;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          readout_req = 1'b0;
  logic          data_ready = 1'b0;
  logic [RW-1:0] wraddress_triggerpoint = '0;
  logic [RW-1:0] triggerpoint = '0;
  logic [RW-1:0] nsmp = '0;
  logic [3:0]    chanmask = '0;
  logic          rearm = 1'b0;
  logic          rden;
  logic [RW-1:0] rdaddress;
  logic [1:0]    chansel;
  logic [7:0]    ram_q;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          startTrigger;

  int n_checks = 0;
  int n_fail   = 0;
  int byte_cnt = 0;
  int st_cnt   = 0;
  bit bp_mode  = 1'b0;

  logic [7:0]  exp_bytes[$];
  logic [11:0] exp_addr[$];
  logic [7:0]  pipe[LAT];

  always #5 clk = ~clk;

  readout_sequencer #(.RAM_WIDTH(RW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .readout_req(readout_req), .data_ready(data_ready),
    .wraddress_triggerpoint(wraddress_triggerpoint), .triggerpoint(triggerpoint),
    .nsmp(nsmp), .chanmask(chanmask), .rearm(rearm), .rden(rden),
    .rdaddress(rdaddress), .chansel(chansel), .ram_q(ram_q), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .startTrigger(startTrigger)
  );

  function automatic logic [7:0] ram_val(input logic [1:0] ch, input logic [RW-1:0] a);
    return a[7:0] ^ {ch, 6'b0};
  endfunction

  // Sample RAM: fixed read latency, filler value when not enabled.
  always @(posedge clk) begin
    pipe[0] <= rden ? ram_val(chansel, rdaddress) : 8'h5A;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[LAT-1];

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = bp_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
  end

  // Output monitor: byte/address scoreboards and valid-hold rule.
  initial begin
    logic       prev_wait;
    logic [7:0] prev_data;
    logic [7:0] eb;
    logic [11:0] ea;
    prev_wait = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          n_checks++;
          if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
            n_fail++;
            $display("FAIL hold: tx_valid=%b tx_data=%h, required 1/%h", tx_valid, tx_data, prev_data);
          end
        end
        if (tx_valid && tx_ready) begin
          byte_cnt++;
          n_checks++;
          if (exp_bytes.size() == 0) begin
            n_fail++;
            $display("FAIL byte: got unexpected %h, required none", tx_data);
          end else begin
            eb = exp_bytes.pop_front();
            if (tx_data !== eb) begin
              n_fail++;
              $display("FAIL byte: got %h, required %h", tx_data, eb);
            end
          end
        end
        if (rden) begin
          n_checks++;
          if (exp_addr.size() == 0) begin
            n_fail++;
            $display("FAIL rdaddr: got ch%0d addr %0d, required no read", chansel, rdaddress);
          end else begin
            ea = exp_addr.pop_front();
            if ({chansel, rdaddress} !== ea) begin
              n_fail++;
              $display("FAIL rdaddr: got ch%0d addr %0d, required ch%0d addr %0d",
                       chansel, rdaddress, ea[11:10], ea[9:0]);
            end
          end
        end
        if (startTrigger) st_cnt++;
        prev_wait = tx_valid && !tx_ready;
        prev_data = tx_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [RW-1:0] wtp, input logic [RW-1:0] tp,
                            input logic [RW-1:0] n, input logic [3:0] mask, input logic dr);
    logic [RW-1:0] base;
    base = wtp - tp;
    if (!dr) begin
      exp_bytes.push_back(8'hEE);
    end else begin
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back({4'h0, mask});
      for (int ch = 0; ch < 4; ch++) begin
        if (mask[ch]) begin
          for (int i = 0; i < int'(n); i++) begin
            exp_bytes.push_back(ram_val(ch[1:0], base + RW'(i)));
            exp_addr.push_back({ch[1:0], base + RW'(i)});
          end
        end
      end
    end
  endtask

  task automatic issue_req(input logic [RW-1:0] wtp, input logic [RW-1:0] tp,
                           input logic [RW-1:0] n, input logic [3:0] mask,
                           input logic rr, input logic dr);
    wraddress_triggerpoint = wtp;
    triggerpoint = tp;
    nsmp = n;
    chanmask = mask;
    rearm = rr;
    data_ready = dr;
    @(posedge clk); #1 readout_req = 1'b1;
    @(posedge clk); #1 readout_req = 1'b0;
    // Scramble inputs: the snapshot must hold the accepted values.
    wraddress_triggerpoint = RW'($urandom);
    triggerpoint = RW'($urandom);
    nsmp = RW'($urandom);
    chanmask = 4'($urandom);
    rearm = ~rr;
    data_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [RW-1:0] wtp, input logic [RW-1:0] tp,
                           input logic [RW-1:0] n, input logic [3:0] mask,
                           input logic rr, input logic dr, input bit dbl, input string name);
    int cyc;
    int exp_st;
    push_frame(wtp, tp, n, mask, dr);
    st_cnt = 0;
    exp_st = (rr && dr) ? 1 : 0;
    issue_req(wtp, tp, n, mask, rr, dr);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_rise: got %b, required 1", name, busy);
    end
    if (dbl) begin
      repeat (3) @(posedge clk);
      #1 readout_req = 1'b1; data_ready = 1'b1;
      @(posedge clk); #1 readout_req = 1'b0; data_ready = 1'b0;
    end
    cyc = 0;
    while (cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (busy !== 1'b1) break;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_timeout: busy=%b after %0d cycles, required 0", name, busy, cyc);
    end
    n_checks++;
    if (exp_bytes.size() != 0 || exp_addr.size() != 0) begin
      n_fail++;
      $display("FAIL %s frame_len: %0d bytes and %0d reads missing, required 0",
               name, exp_bytes.size(), exp_addr.size());
    end
    n_checks++;
    if (st_cnt != exp_st) begin
      n_fail++;
      $display("FAIL %s startTrigger: got %0d pulses, required %0d", name, st_cnt, exp_st);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: busy=%b tx_valid=%b, required 0/0", name, busy, tx_valid);
    end
    exp_bytes.delete();
    exp_addr.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({rden, rdaddress, chansel, tx_data, tx_valid, busy, startTrigger} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h, required 0",
               {rden, rdaddress, chansel, tx_data, tx_valid, busy, startTrigger});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({rden, rdaddress, chansel, tx_data, tx_valid, busy, startTrigger} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: outputs=%h, required 0",
               {rden, rdaddress, chansel, tx_data, tx_valid, busy, startTrigger});
    end
  endtask

  task automatic test_basic();
    run_frame(10'd100, 10'd2, 10'd4, 4'b0001, 1'b0, 1'b1, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_frame(10'd1, 10'd3, 10'd4, 4'b1010, 1'b1, 1'b1, 1'b0, "wrap");
  endtask

  task automatic test_backpressure();
    bp_mode = 1'b1;
    run_frame(10'd1, 10'd3, 10'd4, 4'b1010, 1'b1, 1'b1, 1'b0, "bp_wrap");
    run_frame(10'd100, 10'd2, 10'd4, 4'b0001, 1'b0, 1'b1, 1'b0, "bp_basic");
    run_frame(10'd7, 10'd7, 10'd2, 4'b0000, 1'b0, 1'b0, 1'b0, "bp_nak");
    bp_mode = 1'b0;
  endtask

  task automatic test_not_ready();
    run_frame(10'd50, 10'd5, 10'd4, 4'b0011, 1'b1, 1'b0, 1'b0, "not_ready");
  endtask

  task automatic test_empty();
    run_frame(10'd20, 10'd1, 10'd4, 4'b0000, 1'b1, 1'b1, 1'b0, "empty_mask");
    run_frame(10'd20, 10'd1, 10'd0, 4'b1111, 1'b0, 1'b1, 1'b0, "empty_nsmp");
  endtask

  task automatic test_back_to_back();
    run_frame(10'd1023, 10'd0, 10'd3, 4'b0101, 1'b1, 1'b1, 1'b1, "busy_req");
    run_frame(10'd500, 10'd10, 10'd2, 4'b1100, 1'b0, 1'b1, 1'b0, "b2b_next");
  endtask

  task automatic test_reset_mid();
    int cyc;
    push_frame(10'd100, 10'd2, 10'd8, 4'b0001, 1'b1);
    byte_cnt = 0;
    st_cnt = 0;
    issue_req(10'd100, 10'd2, 10'd8, 4'b0001, 1'b1, 1'b1);
    cyc = 0;
    while (byte_cnt < 5 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (byte_cnt < 5) begin
      n_fail++;
      $display("FAIL rst_mid_progress: got %0d bytes, required 5", byte_cnt);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({tx_valid, rden, busy, startTrigger} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_async: tx_valid/rden/busy/startTrigger=%b, required 0000",
               {tx_valid, rden, busy, startTrigger});
    end
    exp_bytes.delete();
    exp_addr.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (st_cnt != 0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: startTrigger pulses=%0d tx_valid=%b, required 0/0", st_cnt, tx_valid);
    end
    run_frame(10'd100, 10'd2, 10'd4, 4'b0001, 1'b0, 1'b1, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_not_ready();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
